// File: rtl/mmio_wr_demux_pkg.sv
// Shared definitions for the MMIO write demux: FSM encodings, default region map, port indices.
package mmio_wr_demux_pkg;

    localparam logic [31:0] DEF_BASE    = 32'h1000_0000;
    localparam int          DEF_RGN_LSB = 12;

    localparam int PORT_RAM  = 0;
    localparam int PORT_LED  = 1;
    localparam int PORT_UART = 2;
    localparam int PORT_TMR  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/mmio_wr_demux_if.sv
// CPU-side write request plus per-target valid/ready and shared write buses.
interface mmio_wr_demux_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int NPORT  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_W-1:0]     in_addr;
    logic [WIDTH-1:0]      in_data;
    logic [WIDTH/8-1:0]    in_be;
    logic [NPORT-1:0]      out_valid;
    logic [NPORT-1:0]      out_ready;
    logic [ADDR_W-1:0]     out_addr;
    logic [WIDTH-1:0]      out_data;
    logic [WIDTH/8-1:0]    out_be;
    logic                  err;

    // slave: the demux itself; master: the CPU store path plus the targets
    modport slave (
        input  in_valid, in_addr, in_data, in_be, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_be, err
    );
    modport master (
        output in_valid, in_addr, in_data, in_be, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_be, err
    );
endinterface

// File: rtl/mmio_addr_decode.sv
// Combinational region decode: only the address bits at and above the region field are needed.
module mmio_addr_decode #(
    parameter int              ADDR_W  = 32,
    parameter int              NPORT   = 4,
    parameter int              RGN_LSB = 12,
    parameter logic [ADDR_W-1:0] BASE  = 32'h1000_0000
) (
    input  logic [ADDR_W-RGN_LSB-1:0] addr_hi,
    output logic [$clog2(NPORT)-1:0]  sel,
    output logic                      mapped
);
    localparam int SELW = $clog2(NPORT);

    assign sel    = addr_hi[SELW-1:0];
    assign mapped = (addr_hi[ADDR_W-RGN_LSB-1:SELW] == BASE[ADDR_W-1:RGN_LSB+SELW]);
endmodule

// File: rtl/mmio_wr_demux.sv
// Routes one CPU write to one of NPORT targets by address region; unmapped writes pulse err.
// Optional MMIO_WR_DEMUX_CNT_EN adds per-port handshake counters and an unmapped-write counter.
module mmio_wr_demux
    import mmio_wr_demux_pkg::*;
#(
    parameter int              WIDTH   = 32,
    parameter int              ADDR_W  = 32,
    parameter int              NPORT   = 4,
    parameter int              RGN_LSB = DEF_RGN_LSB,
    parameter logic [ADDR_W-1:0] BASE  = DEF_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef MMIO_WR_DEMUX_CNT_EN
    output logic [NPORT*16-1:0]  cnt_wr,
    output logic [15:0]          cnt_err,
`endif
    mmio_wr_demux_if.slave       bus
);
    localparam int SELW = $clog2(NPORT);
    localparam int BEW  = WIDTH / 8;

    state_e            state, state_d;
    logic [SELW-1:0]   sel, sel_q;
    logic              mapped, rdy, accept, hs, load;
    logic [NPORT-1:0]  ov_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  data_q;
    logic [BEW-1:0]    be_q;

    mmio_addr_decode #(
        .ADDR_W (ADDR_W),
        .NPORT  (NPORT),
        .RGN_LSB(RGN_LSB),
        .BASE   (BASE)
    ) u_dec (
        .addr_hi(bus.in_addr[ADDR_W-1:RGN_LSB]),
        .sel    (sel),
        .mapped (mapped)
    );

    // In BUSY, in_ready follows the selected target so a draining slot can refill the same cycle.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        rdy     = 1'b0;
        case (state)
            ST_IDLE: rdy = 1'b1;
            ST_BUSY: rdy = bus.out_ready[sel_q];
            default: rdy = 1'b0;
        endcase
        accept = bus.in_valid & rdy;
        hs     = (state == ST_BUSY) & bus.out_ready[sel_q];
        if (state == ST_ERR) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            if (mapped) begin
                load    = 1'b1;
                state_d = ST_BUSY;
            end else begin
                state_d = ST_ERR;
            end
        end else if (hs) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ov_q   <= '0;
            sel_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                sel_q  <= sel;
                ov_q   <= NPORT'(1) << sel;
                addr_q <= bus.in_addr;
                data_q <= bus.in_data;
                be_q   <= bus.in_be;
            end else if (state_d != ST_BUSY) begin
                ov_q <= '0;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = ov_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_data  = data_q;
    assign bus.out_be    = be_q;
    assign bus.err       = (state == ST_ERR);

`ifdef MMIO_WR_DEMUX_CNT_EN
    logic [NPORT-1:0][15:0] cnt_q;
    logic [15:0]            cnt_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            cnt_err_q <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++)
                if (hs && sel_q == SELW'(p))
                    cnt_q[p] <= cnt_q[p] + 16'd1;
            if (state == ST_ERR && cnt_err_q != 16'hFFFF)
                cnt_err_q <= cnt_err_q + 16'd1;
        end
    end

    assign cnt_wr  = cnt_q;
    assign cnt_err = cnt_err_q;
`endif

endmodule

// File: tb/tb_mmio_wr_demux.sv
// Scoreboard bench for mmio_wr_demux: driver queues expected writes/errors, monitor pops on handshake/err.
module tb_mmio_wr_demux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_wr_demux_if #(.WIDTH(32), .ADDR_W(32), .NPORT(4)) bus ();

`ifdef MMIO_WR_DEMUX_CNT_EN
    logic [63:0] cnt_wr;
    logic [15:0] cnt_err;
`endif

    mmio_wr_demux #(
        .WIDTH(32), .ADDR_W(32), .NPORT(4), .RGN_LSB(12), .BASE(32'h1000_0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef MMIO_WR_DEMUX_CNT_EN
        .cnt_wr (cnt_wr),
        .cnt_err(cnt_err),
`endif
        .bus    (bus)
    );

    typedef struct {
        bit          is_err;
        int          port;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } exp_t;

    exp_t q[$];
    int nvec = 0;
    int nmis = 0;
    int npop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // exp_port: target index, -1 for unmapped, -2 for a write that will be dropped by reset
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input int exp_port, output int waits);
        exp_t e;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.in_be    = be;
        @(negedge clk);
        while (!bus.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            nvec++;
            nmis++;
            $display("FAIL accept_timeout: addr %0h not accepted in 50 cycles", a);
        end else if (exp_port != -2) begin
            e.is_err = (exp_port == -1);
            e.port   = exp_port;
            e.a      = a;
            e.d      = d;
            e.be     = be;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.err) begin
                nvec++;
                if (q.size() == 0) begin
                    nmis++;
                    $display("FAIL sb_err: unexpected err pulse, queue empty");
                end else begin
                    e = q.pop_front();
                    npop++;
                    if (!e.is_err) begin
                        nmis++;
                        $display("FAIL sb_err: got err, expected write to port %0d", e.port);
                    end
                end
            end
            if ((bus.out_valid & bus.out_ready) != 4'b0) begin
                nvec++;
                if (q.size() == 0) begin
                    nmis++;
                    $display("FAIL sb_wr: unexpected handshake out_valid=%b", bus.out_valid);
                end else begin
                    e = q.pop_front();
                    npop++;
                    if (e.is_err || bus.out_valid !== (4'b0001 << e.port) || bus.out_addr !== e.a ||
                        bus.out_data !== e.d || bus.out_be !== e.be) begin
                        nmis++;
                        $display("FAIL sb_wr: got v=%b a=%h d=%h be=%h, expected port %0d a=%h d=%h be=%h err=%0d",
                                 bus.out_valid, bus.out_addr, bus.out_data, bus.out_be,
                                 e.port, e.a, e.d, e.be, e.is_err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int p0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.in_be     = '0;
        bus.out_ready = '0;

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_err",       64'(bus.err),       64'h0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'h1);
        chk("rst_out_data",  64'(bus.out_data),  64'h0);
`ifdef MMIO_WR_DEMUX_CNT_EN
        chk("rst_cnt_wr",  cnt_wr,         64'h0);
        chk("rst_cnt_err", 64'(cnt_err),   64'h0);
`endif

        // single write to LED port
        bus.out_ready = 4'b0010;
        wr(32'h1000_1004, 32'h0000_00AA, 4'hF, 1, w);
        chk("t2_latency_valid", 64'(bus.out_valid), 64'h2);
        chk("t2_data",          64'(bus.out_data),  64'hAA);
        @(posedge clk); #1;
        chk("t2_drained", 64'(bus.out_valid), 64'h0);

        // stalled write to timer port
        bus.out_ready = 4'b0000;
        wr(32'h1000_3008, 32'h0000_0055, 4'h3, 3, w);
        p0 = npop;
        for (int i = 0; i < 5; i++) begin
            chk("t3_in_ready",  64'(bus.in_ready),  64'h0);
            chk("t3_out_valid", 64'(bus.out_valid), 64'h8);
            chk("t3_out_data",  64'(bus.out_data),  64'h55);
            chk("t3_out_addr",  64'(bus.out_addr),  64'h1000_3008);
            @(posedge clk); #1;
        end
        bus.out_ready = 4'b1000;
        @(posedge clk); #1;
        chk("t3_released", 64'(bus.out_valid), 64'h0);
        repeat (2) @(posedge clk); #1;
        chk("t3_once", 64'(npop - p0), 64'h1);

        // back-to-back writes, no bubbles
        bus.out_ready = 4'hF;
        wr(32'h1000_0000, 32'h1111_1111, 4'h1, 0, w);
        chk("t4_wait0",  64'(w), 64'h0);
        chk("t4_valid0", 64'(bus.out_valid), 64'h1);
        wr(32'h1000_1000, 32'h2222_2222, 4'h2, 1, w);
        chk("t4_wait1",  64'(w), 64'h0);
        chk("t4_valid1", 64'(bus.out_valid), 64'h2);
        wr(32'h1000_2000, 32'h3333_3333, 4'hC, 2, w);
        chk("t4_wait2",  64'(w), 64'h0);
        chk("t4_valid2", 64'(bus.out_valid), 64'h4);
        @(posedge clk); #1;
        chk("t4_drained", 64'(bus.out_valid), 64'h0);
`ifdef MMIO_WR_DEMUX_CNT_EN
        chk("t4_cnt_wr", cnt_wr, 64'h0001_0001_0002_0001);
`endif

        // unmapped write
        wr(32'h2000_0000, 32'hDEAD_BEEF, 4'hF, -1, w);
        chk("t5_err_pulse",  64'(bus.err),       64'h1);
        chk("t5_no_valid",   64'(bus.out_valid), 64'h0);
        chk("t5_in_ready",   64'(bus.in_ready),  64'h0);
        @(posedge clk); #1;
        chk("t5_err_clear",  64'(bus.err),       64'h0);
        chk("t5_ready_back", 64'(bus.in_ready),  64'h1);
`ifdef MMIO_WR_DEMUX_CNT_EN
        chk("t5_cnt_err", 64'(cnt_err), 64'h1);
`endif

        // reset while a write to UART port is pending
        bus.out_ready = 4'b0000;
        wr(32'h1000_2010, 32'h4444_4444, 4'hF, -2, w);
        chk("t6_pending", 64'(bus.out_valid), 64'h4);
`ifdef MMIO_WR_DEMUX_CNT_EN
        chk("t6_cnt_before", 64'(cnt_wr[47:32]), 64'h1);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_dropped", 64'(bus.out_valid), 64'h0);
`ifdef MMIO_WR_DEMUX_CNT_EN
        chk("t6_cnt_cleared", 64'(cnt_wr[47:32]), 64'h0);
`endif
        rst = 1'b0;
        bus.out_ready = 4'hF;
        repeat (5) @(posedge clk); #1;
        chk("t6_no_late", 64'(bus.out_valid), 64'h0);

        chk("sb_empty", 64'(q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
